// File: rtl/l2_control.sv
//==============================================================================
// Module   : l2_control
// Purpose  : Sequencing FSM for the 4-way L2 cache, including the pmem
//            writeback/fill handshake and saturating hit/miss/writeback counters.
// Revision : 1.0
//==============================================================================
`default_nettype none

module l2_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 hit,
   input  logic [1:0]           lru,
   input  logic [3:0]           dirty,
   input  logic                 pmem_resp,
   input  logic                 perf_clear,
   output logic                 idling,
   output logic                 tag_comp,
   output logic                 alloc_dirty0_write,
   output logic                 alloc_dirty1_write,
   output logic                 alloc_dirty2_write,
   output logic                 alloc_dirty3_write,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 pmem_addr_sel,
   output logic                 dirty_in,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_TAG_COMP  = 2'd1,
      ST_WRITEBACK = 2'd2,
      ST_ALLOCATE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t               state_q, state_d;
   logic [1:0]           victim_q, victim_d;
   logic                 refill_q, refill_d;
   logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
   logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

   logic w_req;
   logic w_hit_inc;
   logic w_miss_inc;
   logic w_wb_inc;

   function automatic logic [CNT_WIDTH-1:0] sat_next(
      input logic [CNT_WIDTH-1:0] cnt,
      input logic                 inc,
      input logic                 clr
   );
      if (clr)
         return '0;
      else if (inc && (cnt != C_CNT_MAX))
         return cnt + C_CNT_ONE;
      else
         return cnt;
   endfunction

   assign w_req = mem_read | mem_write;

   always_comb begin
      state_d    = state_q;
      victim_d   = victim_q;
      refill_d   = refill_q;
      w_miss_inc = 1'b0;
      w_wb_inc   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_req && !hit)
               state_d = ST_TAG_COMP;
         end
         ST_TAG_COMP: begin
            if (!w_req || hit) begin
               state_d = ST_IDLE;
            end else begin
               victim_d   = lru;
               w_miss_inc = 1'b1;
               state_d    = dirty[lru] ? ST_WRITEBACK : ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            if (pmem_resp) begin
               w_wb_inc = 1'b1;
               state_d  = ST_ALLOCATE;
            end
         end
         ST_ALLOCATE: begin
            if (pmem_resp) begin
               refill_d = 1'b1;
               state_d  = ST_TAG_COMP;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A refill only suppresses the hit count until the request completes.
      if (state_d == ST_IDLE)
         refill_d = 1'b0;
   end

   assign w_hit_inc = w_req && hit && !refill_q &&
                      ((state_q == ST_IDLE) || (state_q == ST_TAG_COMP));

   always_comb begin
      hit_cnt_d  = sat_next(hit_cnt_q,  w_hit_inc,  perf_clear);
      miss_cnt_d = sat_next(miss_cnt_q, w_miss_inc, perf_clear);
      wb_cnt_d   = sat_next(wb_cnt_q,   w_wb_inc,   perf_clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         victim_q   <= 2'd0;
         refill_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         victim_q   <= victim_d;
         refill_q   <= refill_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   assign idling             = (state_q == ST_IDLE);
   assign tag_comp           = (state_q == ST_TAG_COMP);
   assign pmem_write         = (state_q == ST_WRITEBACK);
   assign pmem_read          = (state_q == ST_ALLOCATE);
   assign pmem_addr_sel      = (state_q == ST_WRITEBACK);
   assign alloc_dirty0_write = pmem_read && (victim_q == 2'd0);
   assign alloc_dirty1_write = pmem_read && (victim_q == 2'd1);
   assign alloc_dirty2_write = pmem_read && (victim_q == 2'd2);
   assign alloc_dirty3_write = pmem_read && (victim_q == 2'd3);
   assign dirty_in           = 1'b0;
   assign hit_count          = hit_cnt_q;
   assign miss_count         = miss_cnt_q;
   assign wb_count           = wb_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_control.sv
//==============================================================================
// Module   : tb_l2_control
// Purpose  : Directed plus randomized checking of l2_control against a
//            cycle-level reference model (4-bit counters to reach saturation).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_l2_control;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_read, mem_write, hit, pmem_resp, perf_clear;
   logic [1:0]    lru;
   logic [3:0]    dirty;
   logic          idling, tag_comp, pmem_read, pmem_write, pmem_addr_sel, dirty_in;
   logic          a0, a1, a2, a3;
   logic [CW-1:0] hit_count, miss_count, wb_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase names 0=idle 1=compare 2=writeback 3=fill
   int m_phase, m_victim, m_hits, m_misses, m_wbs;
   bit m_refill;

   always #5 clk = ~clk;

   l2_control #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
      .lru(lru), .dirty(dirty), .pmem_resp(pmem_resp), .perf_clear(perf_clear),
      .idling(idling), .tag_comp(tag_comp),
      .alloc_dirty0_write(a0), .alloc_dirty1_write(a1),
      .alloc_dirty2_write(a2), .alloc_dirty3_write(a3),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr_sel(pmem_addr_sel), .dirty_in(dirty_in),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int bump(input int c, input bit inc, input bit clr);
      if (clr) return 0;
      return (inc && c < CMAX) ? c + 1 : c;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_victim = 0; m_refill = 0;
      m_hits = 0; m_misses = 0; m_wbs = 0;
   endtask

   task automatic model_step();
      bit req, hinc, minc, winc;
      int nxt;
      req  = mem_read | mem_write;
      hinc = req && hit && (m_phase <= 1) && !m_refill;
      minc = (m_phase == 1) && req && !hit;
      winc = (m_phase == 2) && pmem_resp;
      nxt  = m_phase;
      if (m_phase == 0 && req && !hit) nxt = 1;
      else if (m_phase == 1) begin
         if (minc) begin
            m_victim = int'(lru);
            nxt = dirty[lru] ? 2 : 3;
         end else nxt = 0;
      end
      else if (m_phase == 2 && pmem_resp) nxt = 3;
      else if (m_phase == 3 && pmem_resp) begin nxt = 1; m_refill = 1; end
      if (nxt == 0) m_refill = 0;
      m_phase  = nxt;
      m_hits   = bump(m_hits,   hinc, perf_clear);
      m_misses = bump(m_misses, minc, perf_clear);
      m_wbs    = bump(m_wbs,    winc, perf_clear);
   endtask

   task automatic check_all();
      check("idling",     32'(idling),        32'(m_phase == 0));
      check("tag_comp",   32'(tag_comp),      32'(m_phase == 1));
      check("pmem_write", 32'(pmem_write),    32'(m_phase == 2));
      check("pmem_read",  32'(pmem_read),     32'(m_phase == 3));
      check("addr_sel",   32'(pmem_addr_sel), 32'(m_phase == 2));
      check("alloc",      32'({a3, a2, a1, a0}), (m_phase == 3) ? (32'd1 << m_victim) : 32'd0);
      check("dirty_in",   32'(dirty_in),      32'd0);
      check("hit_count",  32'(hit_count),     32'(m_hits));
      check("miss_count", 32'(miss_count),    32'(m_misses));
      check("wb_count",   32'(wb_count),      32'(m_wbs));
   endtask

   // Drive one cycle of inputs, advance model at the edge, check at the next negedge.
   task automatic cyc(input bit rd, input bit wr, input bit h, input logic [1:0] l,
                      input logic [3:0] d, input bit resp, input bit clr);
      mem_read = rd; mem_write = wr; hit = h; lru = l; dirty = d;
      pmem_resp = resp; perf_clear = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic async_reset_pulse();
      #2 reset = 1'b1;
      #1;
      check("rst_idling",     32'(idling),     32'd1);
      check("rst_pmem_write", 32'(pmem_write), 32'd0);
      check("rst_pmem_read",  32'(pmem_read),  32'd0);
      check("rst_counters",   32'({hit_count, miss_count, wb_count}), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      check_all();
   endtask

   initial begin
      reset = 1'b1;
      mem_read = 0; mem_write = 0; hit = 0; lru = 0; dirty = 0;
      pmem_resp = 0; perf_clear = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b0;

      // Zero-wait hit
      cyc(1, 0, 1, 2'd0, 4'h0, 0, 0);
      check("t1_hits", 32'(hit_count), 32'd1);
      cyc(0, 0, 0, 2'd0, 4'h0, 0, 0);

      // Clean miss on way 2, refill then hit
      cyc(1, 0, 0, 2'd2, 4'h0, 0, 0);
      cyc(1, 0, 0, 2'd2, 4'h0, 0, 0);
      check("t2_alloc2", 32'(a2), 32'd1);
      cyc(1, 0, 0, 2'd2, 4'h0, 1, 0);
      cyc(1, 0, 1, 2'd2, 4'h0, 0, 0);
      check("t2_miss", 32'(miss_count), 32'd1);
      check("t2_hits", 32'(hit_count), 32'd1);

      // Dirty miss on way 1 with a 5-cycle writeback
      cyc(0, 1, 0, 2'd1, 4'b0010, 0, 0);
      cyc(0, 1, 0, 2'd1, 4'b0010, 0, 0);
      repeat (4) cyc(0, 1, 0, 2'd1, 4'b0010, 0, 0);
      cyc(0, 1, 0, 2'd1, 4'b0010, 1, 0);
      check("t3_alloc1", 32'(a1), 32'd1);
      cyc(0, 1, 0, 2'd1, 4'b0010, 1, 0);
      cyc(0, 1, 1, 2'd1, 4'b0010, 0, 0);
      check("t3_wb", 32'(wb_count), 32'd1);

      // Request dropped during fill
      cyc(1, 0, 0, 2'd3, 4'h0, 0, 0);
      cyc(1, 0, 0, 2'd3, 4'h0, 0, 0);
      repeat (3) cyc(0, 0, 0, 2'd3, 4'h0, 0, 0);
      cyc(0, 0, 0, 2'd3, 4'h0, 1, 0);
      cyc(0, 0, 0, 2'd3, 4'h0, 0, 0);
      check("t4_idle", 32'(idling), 32'd1);

      // Asynchronous reset in the middle of a writeback
      cyc(1, 0, 0, 2'd0, 4'b0001, 0, 0);
      cyc(1, 0, 0, 2'd0, 4'b0001, 0, 0);
      cyc(1, 0, 0, 2'd0, 4'b0001, 0, 0);
      async_reset_pulse();

      // Saturation and clear priority
      repeat (17) cyc(1, 0, 1, 2'd0, 4'h0, 0, 0);
      check("t6_sat", 32'(hit_count), 32'd15);
      cyc(1, 0, 1, 2'd0, 4'h0, 0, 1);
      check("t6_clr", 32'(hit_count), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) < 3) begin
            async_reset_pulse();
         end else begin
            cyc($urandom_range(9) < 6, $urandom_range(9) < 3, $urandom_range(9) < 3,
                2'($urandom), 4'($urandom), $urandom_range(9) < 3, $urandom_range(99) < 2);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/l2_control.md
Name: l2_control

Overview:
- Sequencing FSM for the 4-way L2 cache; sits directly upstream of the L2 hit-select logic.
- Produces the `idling` / `tag_comp` phase qualifiers and the per-way allocate strobes that the hit-select logic consumes.
- Drives the physical-memory read/write handshake for victim writeback and line fill.
- Keeps saturating hit/miss/writeback performance counters.

Parameters:
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  upstream read request, held until response
- mem_write  in  1  upstream write request, held until response
- hit  in  1  OR over ways of (valid & tag compare), ungated by state
- lru  in  2  current LRU way of the indexed set
- dirty  in  4  dirty bits of the indexed set, bit n = way n
- pmem_resp  in  1  physical memory completion strobe, one cycle
- idling  out  1  FSM in IDLE
- tag_comp  out  1  FSM in TAG_COMP
- alloc_dirty0_write  out  1  allocate strobe, way 0
- alloc_dirty1_write  out  1  allocate strobe, way 1
- alloc_dirty2_write  out  1  allocate strobe, way 2
- alloc_dirty3_write  out  1  allocate strobe, way 3
- pmem_read  out  1  line fill request
- pmem_write  out  1  victim writeback request
- pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + index
- dirty_in  out  1  value written to the dirty bit on allocate; always 0
- perf_clear  in  1  synchronous clear of all counters
- hit_count  out  CNT_WIDTH  first-pass hits
- miss_count  out  CNT_WIDTH  misses
- wb_count  out  CNT_WIDTH  writebacks performed

Behaviour:
- All outputs are Moore outputs decoded from the registered state or from registers; none depends combinationally on `pmem_resp`.
- Reset (asynchronous, any state, mid-transaction included):
  - state = IDLE; victim = 0; refill flag = 0; all counters = 0.
  - Hence `idling` = 1 and every other output = 0.
- Signal `req` = mem_read | mem_write.
- IDLE:
  - req & hit: stay in IDLE. The hit-select logic responds the same cycle (zero-wait hit).
  - req & !hit: go to TAG_COMP.
  - No request: stay in IDLE.
- TAG_COMP:
  - !req: go to IDLE (request withdrawn).
  - hit: go to IDLE (response given this cycle by the hit-select logic).
  - !hit: latch victim = lru and increment miss_count.
    - dirty[lru] = 1: go to WRITEBACK.
    - dirty[lru] = 0: go to ALLOCATE.
- WRITEBACK:
  - Outputs: pmem_write = 1, pmem_addr_sel = 1.
  - Hold until pmem_resp, then go to ALLOCATE and increment wb_count.
- ALLOCATE:
  - Outputs: pmem_read = 1, pmem_addr_sel = 0, alloc_dirty{victim}_write = 1, dirty_in = 0.
  - Hold until pmem_resp; set refill flag; go to TAG_COMP.
  - The hit-select logic qualifies the way write with pmem_resp and its LRU input. lru is stable during a miss, so lru == victim holds throughout.
- A pmem transaction is never abandoned:
  - If req drops during WRITEBACK or ALLOCATE, the FSM still completes through pmem_resp.
  - It then takes the normal path: TAG_COMP, which sees !req and returns to IDLE.
- pmem_read and pmem_write are never asserted together; at most one alloc strobe is high at any time.
- hit_count:
  - Increments in a cycle with req & hit & (IDLE or TAG_COMP) & !refill.
  - The refill flag clears on any return to IDLE.
- Counters:
  - Saturate at all-ones; they do not wrap.
  - perf_clear takes priority over a same-cycle increment; the result is 0.
- pmem_resp arriving in IDLE or TAG_COMP is ignored.

Test Plan:
1. Reset, then mem_read=1, hit=1 in IDLE → FSM stays in IDLE, idling=1, hit_count=1, pmem_read=0.
2. mem_read=1, hit=0, lru=2, dirty=4'b0000 → IDLE, TAG_COMP, ALLOCATE. In ALLOCATE: pmem_read=1, alloc_dirty2_write=1, dirty_in=0. After pmem_resp (drive hit=1): TAG_COMP, then IDLE. Counters: miss_count=1, hit_count=0.
3. mem_write=1, hit=0, lru=1, dirty=4'b0010 → sequence TAG_COMP, WRITEBACK (pmem_write=1, addr_sel=1, held for 5 cycles until pmem_resp), ALLOCATE (alloc_dirty1_write=1), TAG_COMP, IDLE. Counters: wb_count=1, miss_count=1.
4. Drop mem_read during ALLOCATE → pmem_read stays 1 until pmem_resp; then TAG_COMP, then IDLE, with no hit_count increment.
5. Assert reset during WRITEBACK → same cycle: idling=1, pmem_write=0, all counters 0.
6. With CNT_WIDTH=4, produce 17 hits → hit_count=15. Then assert perf_clear together with a hit → hit_count=0.
